// File: rtl/cla_word_sequencer_pkg.sv
// cla_seq_pkg: shared constants and types for the byte-serial wide adder.
//   BYTE_W    : width of one adder beat
//   state_t   : sequencer FSM encoding
//   idx_width : width of the byte index for a given byte count
package cla_seq_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // max(1, clog2(n)), so a one-byte build still gets a 1-bit index
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cla_word_sequencer_if.sv
// cla_word_sequencer_if: request/response bundle between a requester and the
// byte-serial adder.
//   request  : in_valid, in_ready, op_a, op_b, cin (and sub when
//              CLA_SEQ_SUB_MODE_EN is defined)
//   response : out_valid, out_ready, result, cout
// Modports: master = requester side, slave = sequencer side.
interface cla_word_sequencer_if #(parameter int NUM_BYTES = 4);
   import cla_seq_pkg::*;

   logic                        in_valid;
   logic                        in_ready;
   logic [BYTE_W*NUM_BYTES-1:0] op_a;
   logic [BYTE_W*NUM_BYTES-1:0] op_b;
   logic                        cin;
`ifdef CLA_SEQ_SUB_MODE_EN
   logic                        sub;
`endif
   logic                        out_valid;
   logic                        out_ready;
   logic [BYTE_W*NUM_BYTES-1:0] result;
   logic                        cout;

`ifdef CLA_SEQ_SUB_MODE_EN
   modport master (output in_valid, op_a, op_b, cin, sub, out_ready,
                   input  in_ready, out_valid, result, cout);
   modport slave  (input  in_valid, op_a, op_b, cin, sub, out_ready,
                   output in_ready, out_valid, result, cout);
`else
   modport master (output in_valid, op_a, op_b, cin, out_ready,
                   input  in_ready, out_valid, result, cout);
   modport slave  (input  in_valid, op_a, op_b, cin, out_ready,
                   output in_ready, out_valid, result, cout);
`endif

endinterface

// File: rtl/carry_lookahead_adder.sv
// carry_lookahead_adder: 8-bit adder built from generate/propagate terms.
//   A, B : addends
//   Cin  : carry in
//   Sum  : A + B + Cin (low 8 bits)
//   Cout : carry out of bit 7
module carry_lookahead_adder (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Cin,
   output logic [7:0] Sum,
   output logic       Cout
);

   logic [7:0] g;
   logic [7:0] p;
   logic [8:0] c;

   assign g = A & B;
   assign p = A ^ B;

   // Carry recurrence written per bit; it flattens into two-level lookahead terms.
   always_comb begin
      c = '0;
      c[0] = Cin;
      for (int i = 0; i < 8; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
   end

   assign Sum  = p ^ c[7:0];
   assign Cout = c[8];

endmodule

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: adds two NUM_BYTES-byte operands by pushing one byte per
// cycle (LSB first) through a single shared 8-bit carry_lookahead_adder.
//   clk : clock, rising-edge
//   rst : synchronous active-high reset
//   bus : cla_word_sequencer_if.slave (valid/ready request and response)
// Optional build macro CLA_SEQ_SUB_MODE_EN adds the sub input: when set, op_b
// is inverted per byte and the initial carry is forced to 1 (op_a - op_b).
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request
// RUN   | one byte per cycle through the adder
// DONE  | out_valid=1, result/cout held until out_ready
module cla_word_sequencer
   import cla_seq_pkg::*;
#(
   parameter int NUM_BYTES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   cla_word_sequencer_if.slave  bus
);

   localparam int W     = BYTE_W * NUM_BYTES;
   localparam int IDX_W = idx_width(NUM_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   state_t             state;
   state_t             state_nxt;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       result_q;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic               cout_q;
   logic               sub_q;
   logic               sub_in;
   logic               accept;
   logic               last_beat;
   logic [BYTE_W-1:0]  add_a;
   logic [BYTE_W-1:0]  add_b;
   logic               add_cin;
   logic [BYTE_W-1:0]  add_sum;
   logic               add_cout;

`ifdef CLA_SEQ_SUB_MODE_EN
   assign sub_in = bus.sub;
`else
   assign sub_in = 1'b0;
`endif

   assign accept    = (state == IDLE) && bus.in_valid;
   assign last_beat = (idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last_beat) state_nxt = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Byte mux into the shared adder; quiet (all zero) whenever not running.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_a   = a_q[idx*BYTE_W +: BYTE_W];
         add_b   = b_q[idx*BYTE_W +: BYTE_W] ^ {BYTE_W{sub_q}};
         add_cin = carry;
      end
   end

   carry_lookahead_adder u_cla (
      .A    (add_a),
      .B    (add_b),
      .Cin  (add_cin),
      .Sum  (add_sum),
      .Cout (add_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         idx      <= '0;
         carry    <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
      end else begin
         if (accept) begin
            a_q   <= bus.op_a;
            b_q   <= bus.op_b;
            sub_q <= sub_in;
            idx   <= '0;
            // subtraction is A + ~B + 1, so the external carry is ignored
            carry <= sub_in ? 1'b1 : bus.cin;
         end
         if (state == RUN) begin
            result_q[idx*BYTE_W +: BYTE_W] <= add_sum;
            carry <= add_cout;
            idx   <= idx + 1'b1;
            if (last_beat) cout_q <= add_cout;
         end
      end
   end

   assign bus.result = result_q;
   assign bus.cout   = cout_q;

endmodule
